// File: rtl/flopr_sync.sv
// flopr_sync: WIDTH-bit D register with synchronous active-high reset to RESET_VALUE.
module flopr_sync #(
    parameter int          WIDTH       = 1,
    parameter logic [63:0] RESET_VALUE = 64'd0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] y
);
    logic [WIDTH-1:0] y_q, y_d;
    always_comb y_d = reset ? RESET_VALUE[WIDTH-1:0] : d;
    always_ff @(posedge clk) y_q <= y_d;
    assign y = y_q;
endmodule

// File: tb/tb_flopr_sync.sv
// tb_flopr_sync: scoreboard bench driving a 1-bit default instance and a 32-bit PC-style instance side by side.
module tb_flopr_sync;
    localparam logic [31:0] RV32 = 32'h0040_0000;
    logic        clk = 1'b0;
    logic        rst1 = 1'b0, rst32 = 1'b0;
    logic [0:0]  d1 = '0, y1;
    logic [31:0] d32 = '0, y32;
    logic [0:0]  q1[$];
    logic [31:0] q32[$];
    int errors = 0, checks = 0;
    always #5 clk = ~clk;
    flopr_sync u1 (.clk(clk), .reset(rst1), .d(d1), .y(y1));
    flopr_sync #(.WIDTH(32), .RESET_VALUE(64'(RV32))) u32 (.clk(clk), .reset(rst32), .d(d32), .y(y32));
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask
    // Expected results are queued at drive time and retired after the capturing edge.
    task automatic step(input logic r1, input logic v1, input logic r32, input logic [31:0] v32);
        rst1 = r1; d1 = v1; rst32 = r32; d32 = v32;
        q1.push_back(r1 ? 1'b0 : v1);
        q32.push_back(r32 ? RV32 : v32);
        @(posedge clk);
        #1;
        if (q1.size() == 0 || q32.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL scoreboard: empty queue at %0t", $time);
        end else begin
            chk("y1", 64'(y1), 64'(q1.pop_front()));
            chk("y32", 64'(y32), 64'(q32.pop_front()));
        end
    endtask
    initial begin
        step(1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF);
        step(1'b1, 1'b0, 1'b1, 32'h1234_5678);
        step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF);
        step(1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF);
        step(1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF);
        step(1'b0, 1'b1, 1'b0, 32'h0000_0001);
        d1 = 1'b0; d32 = 32'h0; rst1 = 1'b1; rst32 = 1'b1;
        #2;
        rst1 = 1'b0; rst32 = 1'b0;
        #1;
        chk("hold_y1", 64'(y1), 64'd1);
        chk("hold_y32", 64'(y32), 64'd1);
        step(1'b0, 1'b0, 1'b0, 32'h0000_0000);
        step(1'b0, 1'b1, 1'b0, 32'hCAFE_F00D);
        step(1'b1, 1'b1, 1'b1, 32'hAAAA_AAAA);
        step(1'b0, 1'b1, 1'b0, 32'h5555_5555);
        #3;
        d1 = 1'b0; d32 = 32'h0BAD_0BAD;
        @(negedge clk);
        #1;
        chk("negedge_y1", 64'(y1), 64'd1);
        chk("negedge_y32", 64'(y32), 64'h5555_5555);
        step(1'b0, 1'b0, 1'b0, 32'h0BAD_0BAD);
        for (int i = 0; i < 40; i++)
            step(($urandom_range(0, 4) == 0), 1'($urandom), ($urandom_range(0, 4) == 0), $urandom);
        chk("queue_empty", 64'(q1.size() + q32.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
